// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and feeder FSM state encoding for the UART TX feeder.
// Contents: default DATAWIDTH/DEPTH and the IDLE/WAIT_DONE state codes.
package uart_pkg;
    localparam int DATAWIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 16;
    typedef logic [0:0] feeder_state_t;
    localparam feeder_state_t IDLE      = 1'b0;
    localparam feeder_state_t WAIT_DONE = 1'b1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full/empty and occupancy count.
// Ports: clk, rst (sync active-high), push/din (write, dropped while full),
//        pop (advance read pointer, ignored while empty), dout (head entry),
//        full, empty, count (0..DEPTH).
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    localparam int ADDRW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATAWIDTH-1:0] din,
    input  logic                 pop,
    output logic [DATAWIDTH-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRW:0]       count
);
    localparam int CW = ADDRW + 1;
    localparam logic [ADDRW:0]   CNT_ONE  = CW'(1);
    localparam logic [ADDRW:0]   CNT_FULL = CW'(DEPTH);
    localparam logic [ADDRW-1:0] PTR_ONE  = ADDRW'(1);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRW-1:0]     wr_ptr, rd_ptr;
    logic                 do_push, do_pop;
    logic [ADDRW:0]       count_nxt;

    // Registered full gates the write even when a pop lands on the same edge.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign count_nxt = (do_push && !do_pop) ? count + CNT_ONE :
                       (!do_push && do_pop) ? count - CNT_ONE : count;
    assign dout      = mem[rd_ptr];

    // Storage is never cleared; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and launches them one at a time to a UART transmitter.
// Ports: clk, rst (sync active-high); host side wr_en/wr_data, full, empty, count;
//        transmitter side tx_valid (one-cycle launch), tx_data (held until next launch),
//        tx_busy, tx_done; overflow (sticky dropped-write flag).
// Optional: define UART_TX_FEEDER_OVF_EN to build the overflow flag; otherwise it is tied 0.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    localparam int ADDRW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRW:0]       count,
    output logic                 tx_valid,
    output logic [DATAWIDTH-1:0] tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 overflow
);
    feeder_state_t        state;
    logic                 launch;
    logic [DATAWIDTH-1:0] head;

    // A launch is also the FIFO pop; tx_busy in IDLE covers a still-running stop bit.
    assign launch = (state == IDLE) && !empty && !tx_busy;

    uart_sync_fifo #(
        .DATAWIDTH(DATAWIDTH),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (wr_en),
        .din  (wr_data),
        .pop  (launch),
        .dout (head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_valid <= launch;
            if (launch) tx_data <= head;
            state <= launch ? WAIT_DONE :
                     (state == WAIT_DONE && tx_done) ? IDLE : state;
        end
    end

`ifdef UART_TX_FEEDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif
endmodule
